spi_regfile_slave: RTL and testbench

SPI_REGFILE_SLAVE -- requirements
Module: spi_regfile_slave

---
 rtl/spi_regfile_slave.sv | 219 +++++++++++++++++++++
 tb/tb_spi_regfile_slave.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_slave.sv
// SPI mode-0 slave giving an external master read/write access to a small
// register file. All SPI pins are brought into the clk domain and handled
// there; the register file, strobes and frame pulse are plain clk-domain flops.
//
// Frame: CS low, one command byte (bit 7 = read, bits 6:0 = start address),
// then any number of DATA_W-bit words; the address advances after each word.
module spi_regfile_slave #(
  parameter int                          DATA_W    = 8,
  parameter int                          NUM_REGS  = 8,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_sclk,
  input  logic                         spi_cs_n,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA
  } state_e;

  // Synchroniser and edge-detect state
  logic [1:0] sclk_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sclk_prev_q;
  logic       sclk_s;
  logic       cs_s;
  logic       mosi_s;
  logic       sclk_rise;
  logic       sclk_fall;

  // Frame state
  state_e              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_d;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   rd_sr_q;
  logic [DATA_W-1:0]   rd_word_d;
  logic                miso_q;
  logic                wr_pend_q;
  logic                rd_load_q;
  logic                frame_done_q;
  logic                armed_q;
  logic                wr_en;

  // Register file
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]        wr_strobe_q;

  // Two-flop synchronisers for all SPI inputs plus the SCLK edge detector.
  // CS resets to "low" so a CS already low at reset release is not mistaken
  // for a fresh idle period; the block must see a real high first.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample their inputs from the same edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Pointer advance: wraps at the top of the implemented file; pointers that
  // started out of range simply count on modulo 128.
  always_comb begin
    // NOTE: combinational outputs get a default first so no path leaves them
    // unassigned, which would otherwise infer a latch.
    ptr_d = ptr_q + 7'd1;
    if (ptr_q == PTR_W'(NUM_REGS - 1)) ptr_d = '0;
  end

  // Read mux: register at the pointer, zero for unimplemented addresses.
  always_comb begin
    rd_word_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ptr_q == PTR_W'(k)) rd_word_d = regs_q[k*DATA_W +: DATA_W];
    end
  end

  // Frame FSM: command decode, data shifting, MISO generation, frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ptr_q        <= '0;
      shift_q      <= '0;
      rd_sr_q      <= '0;
      miso_q       <= 1'b0;
      wr_pend_q    <= 1'b0;
      rd_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      rd_load_q    <= 1'b0;
      if (cs_s) armed_q <= 1'b1;

      if (state_q == IDLE) begin
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
        if (!cs_s && armed_q) state_q <= CMD;
      end else if (cs_s) begin
        // CS release wins over any SCLK edge seen in the same cycle, so a
        // partially shifted word is dropped here.
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
        if (state_q != CMD) frame_done_q <= 1'b1;
      end else begin
        case (state_q)
          CMD: begin
            if (sclk_rise) begin
              shift_q <= {shift_q[DATA_W-2:0], mosi_s};
              if (bit_cnt_q == CNT_W'(7)) begin
                bit_cnt_q <= '0;
                ptr_q     <= {shift_q[5:0], mosi_s};
                state_q   <= shift_q[6] ? RD_DATA : WR_DATA;
                rd_load_q <= shift_q[6];
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end

          WR_DATA: begin
            // The register block commits the word this cycle; move on.
            if (wr_pend_q) ptr_q <= ptr_d;
            if (sclk_rise) begin
              shift_q <= {shift_q[DATA_W-2:0], mosi_s};
              if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                bit_cnt_q <= '0;
                wr_pend_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end

          RD_DATA: begin
            if (rd_load_q) rd_sr_q <= rd_word_d;
            if (sclk_fall) begin
              miso_q  <= rd_sr_q[DATA_W-1];
              rd_sr_q <= {rd_sr_q[DATA_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
              if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                bit_cnt_q <= '0;
                ptr_q     <= ptr_d;
                rd_load_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A completed word is committed one cycle after its last bit, unless CS
  // has risen by then; out-of-range pointers match no register.
  assign wr_en = wr_pend_q & ~cs_s;

  // Register file with per-register write strobes.
  // NOTE: the file is a handful of flops, not a RAM macro, so it takes the
  // async reset and loads RESET_VAL directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= RESET_VAL;
      wr_strobe_q <= '0;
    end else begin
      wr_strobe_q <= '0;
      if (wr_en) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (ptr_q == PTR_W'(k)) begin
            regs_q[k*DATA_W +: DATA_W] <= shift_q;
            wr_strobe_q[k]             <= 1'b1;
          end
        end
      end
    end
  end

  assign spi_miso_oe = (state_q == RD_DATA);
  assign spi_miso    = miso_q & spi_miso_oe;
  assign regs_out    = regs_q;
  assign wr_strobe   = wr_strobe_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Self-checking bench for spi_regfile_slave: directed frame table, hand
// sequences for aborted frames and reset, then random frames against a
// register-array model of the SPI protocol.
module tb_spi_regfile_slave;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam logic [63:0] RST_VAL = 64'h7766_5544_3322_1196;

  typedef logic [3:0][7:0] b4_t;

  typedef struct {
    logic [7:0]  cmd;
    int          n;
    b4_t         tx;
    b4_t         rx;
    logic [63:0] regs;
    logic [7:0]  mask;
    int          cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [63:0] regs_out;
  logic [7:0]  wr_strobe;
  logic        frame_done;

  spi_regfile_slave #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RESET_VAL(RST_VAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .regs_out   (regs_out),
    .wr_strobe  (wr_strobe),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int oe_bad;

  // Output monitor, sampled on the falling clk edge.
  int          strobe_cnt [NUM_REGS];
  int          strobe_cyc = 0;
  int          fd_cnt     = 0;
  int          inv_err    = 0;
  int          stray      = 0;
  logic [63:0] regs_prev  = '0;

  initial for (int k = 0; k < NUM_REGS; k++) strobe_cnt[k] = 0;

  always @(negedge clk) begin
    for (int k = 0; k < NUM_REGS; k++) if (wr_strobe[k]) strobe_cnt[k]++;
    if (wr_strobe != 0) strobe_cyc++;
    if (frame_done) fd_cnt++;
    if (!spi_miso_oe && spi_miso) inv_err++;
    if (!rst && regs_out != regs_prev && wr_strobe == 0) stray++;
    regs_prev = regs_out;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol model: plain array of registers and the address-walk rules.
  logic [7:0] m_regs [NUM_REGS];

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = RST_VAL[k*8 +: 8];
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*8 +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic model_frame(input logic [7:0] cmd, input int n, input b4_t tx,
                             output b4_t rx, output logic [7:0] mask, output int cyc);
    int p;
    p = int'(cmd[6:0]);
    rx = '0; mask = '0; cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (cmd[7]) begin
        rx[i] = (p < NUM_REGS) ? m_regs[p] : 8'h00;
      end else if (p < NUM_REGS) begin
        m_regs[p] = tx[i];
        mask[p]   = 1'b1;
        cyc++;
      end
      p = (p == NUM_REGS - 1) ? 0 : (p + 1) % 128;
    end
  endtask

  // SPI master helpers. All edges land 2 ns after a clk rise.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input logic exp_oe,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      #50;
      spi_sclk = 1'b1;
      rx[7-i]  = spi_miso;
      if (spi_miso_oe !== exp_oe) oe_bad++;
      #50;
      spi_sclk = 1'b0;
    end
  endtask

  int s0 [NUM_REGS];
  int c0, f0;

  task automatic snap();
    for (int k = 0; k < NUM_REGS; k++) s0[k] = strobe_cnt[k];
    c0 = strobe_cyc;
    f0 = fd_cnt;
    oe_bad = 0;
  endtask

  task automatic delta(output logic [7:0] mask, output int cyc, output int fd);
    mask = '0;
    for (int k = 0; k < NUM_REGS; k++) if (strobe_cnt[k] != s0[k]) mask[k] = 1'b1;
    cyc = strobe_cyc - c0;
    fd  = fd_cnt - f0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int n, input b4_t tx,
                           output b4_t rx, output logic [7:0] mask,
                           output int cyc, output int fd);
    logic [7:0] d;
    snap();
    rx = '0;
    spi_cs_n = 1'b0;
    #50;
    spi_byte(cmd, 8, 1'b0, d);
    for (int i = 0; i < n; i++) begin
      spi_byte(tx[i], 8, cmd[7], d);
      rx[i] = d;
    end
    #50;
    spi_cs_n = 1'b1;
    #150;
    if (spi_miso_oe !== 1'b0) oe_bad++;
    delta(mask, cyc, fd);
  endtask

  function automatic b4_t b4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  // Run a frame through both DUT and model and compare everything.
  task automatic model_check(input string tag, input logic [7:0] cmd, input int n, input b4_t tx);
    b4_t rx, erx;
    logic [7:0] mask, emask;
    int cyc, ecyc, fd;
    model_frame(cmd, n, tx, erx, emask, ecyc);
    run_frame(cmd, n, tx, rx, mask, cyc, fd);
    check({tag, " regs"}, regs_out, model_flat());
    check({tag, " strobe mask"}, mask, emask);
    check({tag, " strobe cycles"}, cyc, ecyc);
    check({tag, " frame_done"}, fd, 1);
    check({tag, " oe"}, oe_bad, 0);
    if (cmd[7]) for (int i = 0; i < n; i++) check($sformatf("%s rx%0d", tag, i), rx[i], erx[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [6];

  initial begin
    b4_t        rx, erx;
    logic [7:0] mask, emask, d;
    int         cyc, ecyc, fd;

    vecs[0] = '{8'h80, 1, b4(8'h00, 8'h00, 8'h00, 8'h00), b4(8'h96, 8'h00, 8'h00, 8'h00),
                64'h7766_5544_3322_1196, 8'h00, 0};
    vecs[1] = '{8'h03, 1, b4(8'hA5, 8'h00, 8'h00, 8'h00), b4(8'h00, 8'h00, 8'h00, 8'h00),
                64'h7766_5544_A522_1196, 8'h08, 1};
    vecs[2] = '{8'h06, 3, b4(8'h11, 8'h22, 8'h33, 8'h00), b4(8'h00, 8'h00, 8'h00, 8'h00),
                64'h2211_5544_A522_1133, 8'hC1, 3};
    vecs[3] = '{8'h10, 1, b4(8'h5A, 8'h00, 8'h00, 8'h00), b4(8'h00, 8'h00, 8'h00, 8'h00),
                64'h2211_5544_A522_1133, 8'h00, 0};
    vecs[4] = '{8'h90, 1, b4(8'h00, 8'h00, 8'h00, 8'h00), b4(8'h00, 8'h00, 8'h00, 8'h00),
                64'h2211_5544_A522_1133, 8'h00, 0};
    vecs[5] = '{8'h87, 3, b4(8'h00, 8'h00, 8'h00, 8'h00), b4(8'h22, 8'h33, 8'h11, 8'h00),
                64'h2211_5544_A522_1133, 8'h00, 0};

    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    model_reset();
    #20;
    check("reset regs_out", regs_out, RST_VAL);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset frame_done", frame_done, 0);
    check("reset miso", spi_miso, 0);
    check("reset miso_oe", spi_miso_oe, 0);
    #7;
    rst = 1'b0;
    #100;

    // Directed frame table
    for (int v = 0; v < 6; v++) begin
      model_frame(vecs[v].cmd, vecs[v].n, vecs[v].tx, erx, emask, ecyc);
      run_frame(vecs[v].cmd, vecs[v].n, vecs[v].tx, rx, mask, cyc, fd);
      check($sformatf("vec%0d regs", v), regs_out, vecs[v].regs);
      check($sformatf("vec%0d strobe mask", v), mask, vecs[v].mask);
      check($sformatf("vec%0d strobe cycles", v), cyc, vecs[v].cyc);
      check($sformatf("vec%0d frame_done", v), fd, 1);
      check($sformatf("vec%0d oe", v), oe_bad, 0);
      if (vecs[v].cmd[7])
        for (int i = 0; i < vecs[v].n; i++)
          check($sformatf("vec%0d rx%0d", v, i), rx[i], vecs[v].rx[i]);
    end

    // CS raised after 5 data bits of a write to reg2
    snap();
    spi_cs_n = 1'b0; #50;
    spi_byte(8'h02, 8, 1'b0, d);
    spi_byte(8'hFF, 5, 1'b0, d);
    #50; spi_cs_n = 1'b1; #150;
    delta(mask, cyc, fd);
    check("partial regs", regs_out, model_flat());
    check("partial strobes", cyc, 0);
    check("partial frame_done", fd, 1);
    check("partial oe", spi_miso_oe, 0);
    model_check("after partial", 8'h02, 1, b4(8'h5C, 8'h00, 8'h00, 8'h00));

    // CS rise coincident with the final data-bit SCLK rise
    snap();
    spi_cs_n = 1'b0; #50;
    spi_byte(8'h01, 8, 1'b0, d);
    spi_byte(8'h77, 7, 1'b0, d);
    spi_mosi = 1'b1; #50;
    spi_sclk = 1'b1; spi_cs_n = 1'b1; #50;
    spi_sclk = 1'b0; #150;
    delta(mask, cyc, fd);
    check("coincident regs", regs_out, model_flat());
    check("coincident strobes", cyc, 0);
    model_check("after coincident", 8'h81, 2, b4(8'h00, 8'h00, 8'h00, 8'h00));

    // Reset pulsed during a burst read, CS still low at release
    oe_bad = 0;
    spi_cs_n = 1'b0; #50;
    spi_byte(8'h80, 8, 1'b0, d);
    spi_byte(8'h00, 4, 1'b1, d);
    rst = 1'b1;
    #30;
    check("mid reset regs_out", regs_out, RST_VAL);
    check("mid reset wr_strobe", wr_strobe, 0);
    check("mid reset frame_done", frame_done, 0);
    check("mid reset miso", spi_miso, 0);
    check("mid reset miso_oe", spi_miso_oe, 0);
    spi_byte(8'h00, 3, 1'b0, d);
    rst = 1'b0;
    model_reset();
    #50;
    snap();
    spi_byte(8'h01, 8, 1'b0, d);
    spi_byte(8'hEE, 8, 1'b0, d);
    #50; spi_cs_n = 1'b1; #150;
    delta(mask, cyc, fd);
    check("post reset ignored regs", regs_out, RST_VAL);
    check("post reset ignored strobes", cyc, 0);
    check("post reset ignored frame_done", fd, 0);
    check("post reset ignored oe", oe_bad, 0);
    model_check("post reset write", 8'h05, 1, b4(8'h3C, 8'h00, 8'h00, 8'h00));
    model_check("post reset read", 8'h85, 1, b4(8'h00, 8'h00, 8'h00, 8'h00));

    // Random frames against the model
    for (int t = 0; t < 40; t++) begin
      logic [7:0] cmd;
      b4_t        tx;
      cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15))};
      for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
      model_check($sformatf("rand%0d", t), cmd, int'($urandom_range(1, 4)), tx);
    end

    check("miso while oe low", inv_err, 0);
    check("regs change without strobe", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
